dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter: XLEN, 32, data and address width (shared constant).
REQ-002 Parameter: DEPTH_WORDS, 1024, number of 32-bit words stored; power of two.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: mem_en  input  1  request strobe; sampled at each rising clk edge.
REQ-006 Port: mem_wr  input  1  1 = store, 0 = load; meaningful only when mem_en=1.
REQ-007 Port: funct3  input  3  RV32I load/store width code, taken from instruction bits [14:12].
REQ-008 Port: addr  input  XLEN  byte address (EXE-stage ALU result).
REQ-009 Port: wdata  input  XLEN  store data; the low-order bytes are used for SB/SH.
REQ-010 Port: dmem_data  output  XLEN  registered load result; feeds the MEM/WB capture register.
REQ-011 Port: fault  output  1  registered; set for a misaligned or illegal-width access.

Function
REQ-012 Request timing: a request is accepted at rising edge N when mem_en=1 and rst=1.
REQ-013 Load result timing: dmem_data for a load accepted at edge N is stable from shortly after edge N until the next accepted load; read latency is exactly 1 cycle.
REQ-014 Hold behaviour: when mem_en=0, or for a store, dmem_data and all internal state hold their values; no array access occurs.
REQ-015 Word select: word index = addr[log2(DEPTH_WORDS)+1:2], and upper address bits are ignored (wrap-around); byte offset = addr[1:0].
REQ-016 Load extraction: lane data is selected using the byte offset registered at edge N, not the live addr.
  - LB (000): sign-extend the selected byte.
  - LH (001): sign-extend the selected halfword.
  - LW (010): full word.
  - LBU (100): zero-extend the selected byte.
  - LHU (101): zero-extend the selected halfword.
REQ-017 Store byte enables (writes only the enabled lanes at edge N):
  - SB (000): one lane, at the byte offset.
  - SH (001): two lanes, offset 0 or 2.
  - SW (010): all four lanes.
  - wdata is replicated across lanes as needed.
REQ-018 Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - fault=1 from edge N.
  - A store performs no write.
  - A load returns dmem_data=0.
REQ-019 Illegal width: load funct3 ∈ {011,110,111} or store funct3 ∉ {000,001,010}.
  - Treated exactly as misaligned (fault=1, no write, dmem_data=0).
REQ-020 fault update: fault is recomputed at every accepted request and holds otherwise; a clean accepted access clears it.
REQ-021 Load-after-store: a load accepted at edge N+1 to the word stored at edge N returns the new data.
REQ-022 Single port: one access per cycle; there are no simultaneous read and write in the same cycle by construction (mem_wr selects one).
REQ-023 Undefined data: reading a never-written word returns an undefined value in synthesis; the simulation model initialises the array to 0.

Reset
REQ-024 Effect of rst=0 (asynchronous): dmem_data=0, fault=0, and the registered funct3/offset are cleared to 0.
REQ-025 The storage array is not reset; contents are preserved across reset.
REQ-026 A request coincident with an active reset is ignored; no write occurs while rst=0.
REQ-027 Release: the first request is accepted at the first rising edge with rst=1.

Structure
REQ-028 Shared package contents: XLEN, REG_ADDR_WIDTH, and the funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-029 Sub-module dmem_ram: a byte-lane-enabled, single-port, synchronous-read RAM of DEPTH_WORDS x 32.
REQ-030 dmem_resp contents: decode, alignment check, lane steering, registered control, and extraction around dmem_ram.

Verification
REQ-031 Word store/load: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> dmem_data=0xDEADBEEF one cycle later, fault=0.
REQ-032 Byte/halfword extraction: after REQ-031, check each load at 0x13 and 0x12:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x12 -> 0x0000DEAD.
REQ-033 Partial store: SB 0x11 wdata=0x00000055, then LW 0x10 -> 0xDEAD55EF.
REQ-034 Misaligned store: SH 0x11 -> fault=1 and no write (LW 0x10 unchanged); the following clean LW -> fault=0.
REQ-035 Reset mid-operation: assert rst=0 between a load accept and the capture edge -> dmem_data=0 and fault=0 immediately; after release, LW 0x10 returns the pre-reset contents.
REQ-036 Hold and wrap-around: with mem_en=0 for 5 cycles, dmem_data holds; LW 0x10 + 4*DEPTH_WORDS returns the same word as LW 0x10.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_resp_pkg : shared widths, RV32I load/store funct3 codes     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package dmem_resp_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal width or misaligned offset; either one suppresses the access.
  function automatic logic access_bad(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = wr ? !(f3 inside {SB, SH, SW})
                    : !(f3 inside {LB, LH, LW, LBU, LHU});
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_ram : single-port byte-lane RAM, synchronous read           |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Storage is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_resp : data-memory stage; decode, align check, lane steer   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module dmem_resp #(
  parameter int XLEN        = dmem_resp_pkg::XLEN,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_en,
  input  logic            mem_wr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] dmem_data,
  output logic            fault
);
  import dmem_resp_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        req;
  logic        bad;
  logic        ram_en;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  logic [2:0]  f3_q,     f3_d;
  logic [1:0]  off_q,    off_d;
  logic        ld_ok_q,  ld_ok_d;
  logic        fault_q,  fault_d;

  // A request only counts while reset is released, so nothing is written under reset.
  always_comb begin
    req    = mem_en & rst;
    bad    = access_bad(mem_wr, funct3, addr[1:0]);
    ram_en = req & ~bad;
    be     = store_be(funct3, addr[1:0]);
    case (funct3[1:0])
      2'b00:   wlanes = {4{wdata[7:0]}};
      2'b01:   wlanes = {2{wdata[15:0]}};
      default: wlanes = wdata[31:0];
    endcase
  end

  assign unused_addr_bits = ^addr[XLEN-1:AW+2];

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (mem_wr),
    .be    (be),
    .addr  (addr[AW+1:2]),
    .wdata (wlanes),
    .rdata (rdata)
  );

  // Load control only moves on accepted loads so a store leaves dmem_data untouched.
  always_comb begin
    f3_d    = f3_q;
    off_d   = off_q;
    ld_ok_d = ld_ok_q;
    fault_d = fault_q;
    if (req) begin
      fault_d = bad;
      if (!mem_wr) begin
        f3_d    = funct3;
        off_d   = addr[1:0];
        ld_ok_d = ~bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      ld_ok_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_ok_q <= ld_ok_d;
      fault_q <= fault_d;
    end
  end

  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] ext;

  always_comb begin
    sel_byte = rdata[8*off_q +: 8];
    sel_half = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (f3_q)
      LB:      ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LH:      ext = {{(XLEN-16){sel_half[15]}}, sel_half};
      LW:      ext = XLEN'(rdata);
      LBU:     ext = {{(XLEN-8){1'b0}}, sel_byte};
      LHU:     ext = {{(XLEN-16){1'b0}}, sel_half};
      default: ext = '0;
    endcase
    dmem_data = ld_ok_q ? ext : '0;
  end

  assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_resp : directed + randomized checks against a byte model |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int DEPTH_WORDS = 1024;
  localparam int NBYTES      = DEPTH_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] dmem_data;
  logic        fault;

  logic [7:0]  mref [NBYTES];
  logic [31:0] exp_data;
  logic        exp_fault;
  int          checks;
  int          errors;

  dmem_resp #(.XLEN(32), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .dmem_data (dmem_data),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  function automatic logic ref_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int   size;
    logic legal;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % size) != 0);
  endfunction

  // Architectural effect of one accepted request on memory bytes and the outputs.
  task automatic model_apply(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    int          size;
    int          base;
    logic [31:0] v;
    size      = 1 << f3[1:0];
    base      = int'(a % NBYTES);
    exp_fault = ref_bad(wr, f3, a);
    if (wr) begin
      if (!exp_fault)
        for (int k = 0; k < size; k++) mref[base + k] = wd[8*k +: 8];
    end else if (exp_fault) begin
      exp_data = 32'h0;
    end else begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = mref[base + k];
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      exp_data = v;
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    mem_en = 1'b1; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    model_apply(wr, f3, a, wd);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_en = 1'b0; addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_en = 1'b1; mem_wr = 1'b1; funct3 = SW; addr = 32'h10; wdata = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fault, dmem_data} !== 33'h0) begin
      errors++;
      $display("FAIL reset_state: got fault=%b data=%h want fault=0 data=00000000", fault, dmem_data);
    end
    @(negedge clk);
    mem_en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic init_window();
    for (int w = 0; w < 16; w++) issue(1'b1, SW, 32'(w * 4), $urandom);
  endtask

  task automatic test_word();
    issue(1'b1, SW, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, LW, 32'h10, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL word_load: got fault=%b data=%h want fault=0 data=deadbeef", fault, dmem_data);
    end
  endtask

  task automatic test_extract();
    logic [2:0]  f3s  [4] = '{LB, LBU, LH, LHU};
    logic [31:0] as   [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] want [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], as[i], 32'h0);
      checks++;
      if ({fault, dmem_data} !== {1'b0, want[i]}) begin
        errors++;
        $display("FAIL extract_%0d: got fault=%b data=%h want fault=0 data=%h", i, fault, dmem_data, want[i]);
      end
    end
  endtask

  task automatic test_partial();
    issue(1'b1, SB, 32'h11, 32'h0000_0055);
    issue(1'b0, LW, 32'h10, 32'h0);
    checks++;
    if (dmem_data !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL partial_store: got %h want dead55ef", dmem_data);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b1, SH, 32'h11, 32'h0000_9999);
    checks++;
    if ({fault, dmem_data} !== {1'b1, 32'hDEAD_55EF}) begin
      errors++;
      $display("FAIL misaligned_store: got fault=%b data=%h want fault=1 data=dead55ef", fault, dmem_data);
    end
    issue(1'b0, LW, 32'h10, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b0, 32'hDEAD_55EF}) begin
      errors++;
      $display("FAIL misaligned_nowrite: got fault=%b data=%h want fault=0 data=dead55ef", fault, dmem_data);
    end
    issue(1'b0, LW, 32'h12, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL misaligned_load: got fault=%b data=%h want fault=1 data=00000000", fault, dmem_data);
    end
    issue(1'b1, 3'b100, 32'h10, 32'h1234_5678);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL illegal_load: got fault=%b data=%h want fault=1 data=00000000", fault, dmem_data);
    end
    issue(1'b0, LW, 32'h10, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b0, 32'hDEAD_55EF}) begin
      errors++;
      $display("FAIL illegal_store_nowrite: got fault=%b data=%h want fault=0 data=dead55ef", fault, dmem_data);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, SW, 32'h14, 32'hCAFE_F00D);
    issue(1'b0, LW, 32'h14, 32'h0);
    checks++;
    if (dmem_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL load_after_store: got %h want cafef00d", dmem_data);
    end
  endtask

  task automatic test_hold_wrap();
    issue(1'b0, LW, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      checks++;
      if (dmem_data !== 32'hDEAD_55EF) begin
        errors++;
        $display("FAIL hold_%0d: got %h want dead55ef", i, dmem_data);
      end
    end
    issue(1'b1, SW, 32'h30, 32'h0BAD_CAFE);
    checks++;
    if (dmem_data !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL hold_store: got %h want dead55ef", dmem_data);
    end
    issue(1'b0, LW, 32'h10 + 4 * DEPTH_WORDS, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b0, 32'hDEAD_55EF}) begin
      errors++;
      $display("FAIL wrap: got fault=%b data=%h want fault=0 data=dead55ef", fault, dmem_data);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, LW, 32'h14, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    exp_data = 32'h0; exp_fault = 1'b0;
    checks++;
    if ({fault, dmem_data} !== 33'h0) begin
      errors++;
      $display("FAIL reset_async: got fault=%b data=%h want fault=0 data=00000000", fault, dmem_data);
    end
    @(negedge clk);
    mem_en = 1'b1; mem_wr = 1'b1; funct3 = SW; addr = 32'h10; wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    @(negedge clk);
    mem_en = 1'b0;
    rst = 1'b1;
    issue(1'b0, LW, 32'h10, 32'h0);
    checks++;
    if ({fault, dmem_data} !== {1'b0, 32'hDEAD_55EF}) begin
      errors++;
      $display("FAIL reset_preserve: got fault=%b data=%h want fault=0 data=dead55ef", fault, dmem_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle();
      end else begin
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end
      checks++;
      if ({fault, dmem_data} !== {exp_fault, exp_data}) begin
        errors++;
        $display("FAIL random_%0d: got fault=%b data=%h want fault=%b data=%h",
                 n, fault, dmem_data, exp_fault, exp_data);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_data  = 32'h0;
    exp_fault = 1'b0;
    for (int i = 0; i < NBYTES; i++) mref[i] = 8'h00;
    test_reset();
    init_window();
    test_word();
    test_extract();
    test_partial();
    test_misaligned();
    test_back_to_back();
    test_hold_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
